// File: rtl/decoder_proj_fv.sv
// Registered 4-bit code decoder (one-hot / hex 7-seg / BCD 7-seg / thermometer), 1-cycle latency, no backpressure.
// Define DECODER_FV_CHECKS_EN to compile in the embedded assertions and covers.
module decoder_proj_fv #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       io_in,
  output logic [OUT_W-1:0] dec_out,
  output logic             dec_valid,
  output logic             dec_err
);

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_HEX    = 2'b01,
    MODE_BCD    = 2'b10,
    MODE_THERM  = 2'b11
  } mode_e;

  logic [3:0]       w_code;
  logic             w_en;
  mode_e            w_mode;
  logic [6:0]       w_seg;
  logic [OUT_W:0]   w_therm;
  logic [OUT_W-1:0] w_dec;

  logic [OUT_W-1:0] r_out;
  logic             r_valid;
  logic [1:0]       r_mode;
  logic             r_code_hi;

  assign w_code = io_in[3:0];
  assign w_en   = io_in[4];
  assign w_mode = mode_e'(io_in[6:5]);

  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  assign w_seg   = seg7(w_code);
  assign w_therm = ((OUT_W+1)'(2) << w_code) - (OUT_W+1)'(1);

  always_comb begin
    w_dec = '0;
    case (w_mode)
      MODE_ONEHOT: w_dec = OUT_W'(1) << w_code;
      MODE_HEX:    w_dec = {{(OUT_W-7){1'b0}}, w_seg};
      MODE_BCD:    w_dec = (w_code > 4'd9) ? OUT_W'(16'h0040)
                                           : {{(OUT_W-7){1'b0}}, w_seg};
      default:     w_dec = w_therm[OUT_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_mode    <= 2'b00;
      r_code_hi <= 1'b0;
    end else begin
      r_valid <= w_en;
      if (w_en) begin
        r_out     <= w_dec;
        r_mode    <= w_mode;
        r_code_hi <= (w_code > 4'd9);
      end
    end
  end

  // Error is only meaningful in BCD mode; both terms are flops that update together.
  assign dec_out   = r_out;
  assign dec_valid = r_valid;
  assign dec_err   = r_code_hi && (r_mode == MODE_BCD);

`ifdef DECODER_FV_CHECKS_EN
  logic             r_prev_en;
  logic [OUT_W:0]   w_out_p1;

  assign w_out_p1 = {1'b0, r_out} + (OUT_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev_en <= 1'b0;
    else        r_prev_en <= w_en;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!dec_valid || r_prev_en);
      assert (!(dec_valid && r_mode == MODE_ONEHOT) || $onehot(r_out));
      assert (!(dec_valid && r_mode == MODE_THERM) || $onehot(w_out_p1));
      assert (!dec_err || r_mode == MODE_BCD);
    end
  end

  cover property (@(posedge clk) disable iff (!rst_n) dec_valid && r_mode == MODE_ONEHOT);
  cover property (@(posedge clk) disable iff (!rst_n) dec_valid && r_mode == MODE_HEX);
  cover property (@(posedge clk) disable iff (!rst_n) dec_valid && r_mode == MODE_BCD);
  cover property (@(posedge clk) disable iff (!rst_n) dec_valid && r_mode == MODE_THERM);
  cover property (@(posedge clk) disable iff (!rst_n) $rose(dec_err));
`endif

endmodule

// File: tb/tb_decoder_proj_fv.sv
// Directed table-driven bench for decoder_proj_fv plus hand-written reset corner cases.
module tb_decoder_proj_fv;

  logic        clk;
  logic        rst_n;
  logic [6:0]  io_in;
  logic [15:0] dec_out;
  logic        dec_valid;
  logic        dec_err;

  int n_checks;
  int n_errors;

  decoder_proj_fv #(.OUT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_in     (io_in),
    .dec_out   (dec_out),
    .dec_valid (dec_valid),
    .dec_err   (dec_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  in;
    logic [15:0] out;
    logic        vld;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [6:0] in, input logic [15:0] out, input logic vld, input logic err);
    vec_t v;
    v.in = in; v.out = out; v.vld = vld; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [15:0] out, input logic vld, input logic err);
    chk({nm, ".out"}, dec_out, out);
    chk({nm, ".vld"}, {15'd0, dec_valid}, {15'd0, vld});
    chk({nm, ".err"}, {15'd0, dec_err}, {15'd0, err});
  endtask

  logic [15:0] hex_tab [16];

  initial begin
    n_checks = 0;
    n_errors = 0;
    hex_tab = '{16'h003F, 16'h0006, 16'h005B, 16'h004F, 16'h0066, 16'h006D, 16'h007D, 16'h0007,
                16'h007F, 16'h006F, 16'h0077, 16'h007C, 16'h0039, 16'h005E, 16'h0079, 16'h0071};

    for (int i = 0; i < 4; i++) add(7'b1100000, 16'h0000, 1'b0, 1'b0);
    add(7'b0010101, 16'h0020, 1'b1, 1'b0);
    add(7'b0000101, 16'h0020, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) add({2'b01, 1'b1, 4'(c)}, hex_tab[c], 1'b1, 1'b0);
    add({2'b10, 1'b1, 4'd9},  16'h006F, 1'b1, 1'b0);
    add({2'b10, 1'b1, 4'd12}, 16'h0040, 1'b1, 1'b1);
    add({2'b00, 1'b0, 4'd3},  16'h0040, 1'b0, 1'b1);
    add({2'b10, 1'b1, 4'd10}, 16'h0040, 1'b1, 1'b1);
    add({2'b10, 1'b1, 4'd0},  16'h003F, 1'b1, 1'b0);
    add({2'b00, 1'b1, 4'd15}, 16'h8000, 1'b1, 1'b0);
    add({2'b00, 1'b1, 4'd0},  16'h0001, 1'b1, 1'b0);
    add({2'b11, 1'b1, 4'd0},  16'h0001, 1'b1, 1'b0);
    add({2'b11, 1'b1, 4'd7},  16'h00FF, 1'b1, 1'b0);
    add({2'b11, 1'b1, 4'd15}, 16'hFFFF, 1'b1, 1'b0);

    rst_n = 1'b0;
    io_in = 7'b0011111;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    io_in = 7'b1100000;

    foreach (vecs[i]) begin
      io_in = vecs[i].in;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].vld, vecs[i].err);
    end

    // Async reset between edges while dec_out = FFFF.
    io_in = {2'b11, 1'b1, 4'd15};
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_hold", 16'h0000, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    io_in = {2'b00, 1'b1, 4'd3};
    @(posedge clk);
    #1;
    chk_all("post_rst", 16'h0008, 1'b1, 1'b0);
    io_in = {2'b10, 1'b1, 4'd15};
    @(posedge clk);
    #1;
    chk_all("post_rst_bcd", 16'h0040, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decoder_proj_fv.md
Name: decoder_proj_fv

Overview:
- Registered multi-mode decoder for the decoder project's 7-bit user input bus `io_in`.
- Each cycle it can capture a 4-bit code and decode it into a 16-bit pattern, selected by a 2-bit mode: one-hot, hexadecimal 7-segment, BCD 7-segment or thermometer.
- Sits between the chip user I/O pads and the output drivers.
- Serves as the top for formal cover/assert runs of the decoder project.

Parameters:
- OUT_W, 16, width of the decoded output bus (fixed at 16; other values unsupported).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- io_in  input  7  [3:0] code, [4] enable, [6:5] mode.
- dec_out  output  16  registered decoded pattern.
- dec_valid  output  1  high for one cycle after each accepted code.
- dec_err  output  1  registered: last accepted code illegal for its mode.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-edge release):
  - dec_out = 16'h0000, dec_valid = 0, dec_err = 0.
  - The internal mode register resets to 2'b00.
- io_in is sampled on every rising clk edge; there is no input synchronizer (the integrator provides one).
- Enable io_in[4] = 0:
  - dec_out and dec_err hold their values.
  - dec_valid = 0 on the next cycle.
- Enable io_in[4] = 1 (code c = io_in[3:0], mode m = io_in[6:5]): on the next rising edge
  - dec_out = f(m, c), dec_err = e(m, c), dec_valid = 1, mode register = m.
  - Latency is exactly 1 cycle; back-to-back enables give a new result every cycle.
- m = 00, one-hot:
  - dec_out = 1 << c.
  - e = 0.
- m = 01, hex 7-segment, active-high:
  - bits [6:0] = {g,f,e,d,c,b,a}, bits [15:7] = 0.
  - Patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - e = 0.
- m = 10, BCD 7-segment:
  - c ≤ 9: same patterns as m = 01, e = 0.
  - c ≥ 10: dec_out = 16'h0040 (dash, segment g only), e = 1.
- m = 11, thermometer:
  - dec_out bits [c:0] set, i.e. (2 << c) − 1.
  - c = 15 gives 16'hFFFF.
  - e = 0.
- Reset asserted mid-operation clears all outputs immediately, regardless of clk. The first enabled sample after release decodes normally.
- All logic is synchronous to clk except the reset.

Optional Feature:
- Macro DECODER_FV_CHECKS_EN.
- Defined: embedded immediate assertions and covers are compiled in, clocked on clk and disabled while rst_n is low.
  - assert: dec_valid implies the previous-cycle io_in[4] was 1.
  - assert: mode 00 implies dec_out is one-hot.
  - assert: mode 11 implies dec_out + 1 is a power of two.
  - assert: dec_err is only set when the mode is 10.
  - cover: each mode is reached with dec_valid.
  - cover: dec_err rises.
- Not defined: no checking logic, identical port list and function.

Test Plan:
- Reset, then io_in = 7'b1100000 (mode 11, enable 0, code 0) for 4 cycles -> dec_out = 0000, dec_valid = 0, dec_err = 0 throughout.
- io_in = 7'b0010101 (mode 00, enable, code 5) -> next cycle dec_out = 0020, dec_valid = 1; the following cycle with enable 0 gives dec_valid = 0, dec_out holds 0020.
- Mode 01, codes 0..F back-to-back -> dec_out follows the hex segment table with 1-cycle latency; dec_valid stays 1.
- Mode 10, code 9 then code 12 -> 006F with err 0, then 0040 with err 1.
- Mode 11, code 0 / 7 / 15 -> 0001 / 00FF / FFFF.
- Assert rst_n low between clock edges while dec_out = FFFF -> outputs clear to 0 immediately, before the next clk edge.
